// File: rtl/joy_frame_sched_if.sv
// Bus between the video/joystick side and joy_frame_sched: vblank and raw
// buttons in, frame tick and debounced button state out.
interface joy_frame_sched_if;
  logic        vblank;
  logic [4:0]  joy;
  logic        frame_tick;
  logic [4:0]  btn_level;
  logic [4:0]  btn_press;
  logic [15:0] frame_cnt;

  modport master (output vblank, joy,
                  input  frame_tick, btn_level, btn_press, frame_cnt);
  modport slave  (input  vblank, joy,
                  output frame_tick, btn_level, btn_press, frame_cnt);
endinterface

// File: rtl/joy_frame_sched.sv
// Frame-synchronous joystick debouncer with SOCD cleaning and a frame counter.
// Optional direction auto-repeat: define JOY_FRAME_SCHED_AUTOREPEAT_EN.
//   state    | meaning
//   S_IDLE   | direction released, waiting for a press
//   S_DELAY  | pressed, counting frames until the first repeat
//   S_REPEAT | repeating, one pulse every REP_RATE frames
module joy_frame_sched #(
  parameter int DEB_FRAMES = 2,
  parameter int REP_DELAY  = 20,
  parameter int REP_RATE   = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  joy_frame_sched_if.slave   bus
);

  localparam logic [3:0] DEB_CNT = 4'(DEB_FRAMES);

  logic        r_vblank_q;
  logic        r_tick;
  logic [4:0]  r_level;
  logic [4:0]  r_press;
  logic [15:0] r_frame_cnt;
  logic [3:0]  r_deb_cnt [5];

  logic        w_edge;
  logic [4:0]  w_sample;
  logic [4:0]  w_level_nxt;
  logic [4:0]  w_rise;
  logic [4:0]  w_press_all;
  logic [3:0]  w_deb_nxt [5];

  assign w_edge = bus.vblank & ~r_vblank_q;

  // Opposing directions cancel; fire passes through untouched.
  always_comb begin
    w_sample = bus.joy;
    if (bus.joy[3] && bus.joy[2]) w_sample[3:2] = 2'b00;
    if (bus.joy[1] && bus.joy[0]) w_sample[1:0] = 2'b00;
  end

  always_comb begin
    w_level_nxt = r_level;
    w_deb_nxt   = r_deb_cnt;
    w_rise      = '0;
    if (w_edge) begin
      for (int i = 0; i < 5; i++) begin
        if (w_sample[i] == r_level[i]) begin
          w_deb_nxt[i] = '0;
        end else if (r_deb_cnt[i] + 4'd1 == DEB_CNT) begin
          w_level_nxt[i] = ~r_level[i];
          w_deb_nxt[i]   = '0;
        end else begin
          w_deb_nxt[i] = r_deb_cnt[i] + 4'd1;
        end
      end
      w_rise = w_level_nxt & ~r_level;
    end
  end

`ifdef JOY_FRAME_SCHED_AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rep_state_t;

  localparam logic [7:0] DLY_CNT  = 8'(REP_DELAY);
  localparam logic [7:0] RATE_CNT = 8'(REP_RATE);

  rep_state_t r_rep_state [4];
  rep_state_t w_rep_state_nxt [4];
  logic [7:0] r_rep_cnt [4];
  logic [7:0] w_rep_cnt_nxt [4];
  logic [3:0] w_rep_pulse;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_rep_state[i] <= S_IDLE;
        r_rep_cnt[i]   <= '0;
      end
    end else begin
      r_rep_state <= w_rep_state_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
    end
  end

  always_comb begin
    w_rep_state_nxt = r_rep_state;
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_pulse     = '0;
    if (w_edge) begin
      for (int i = 0; i < 4; i++) begin
        if (!w_level_nxt[i]) begin
          w_rep_state_nxt[i] = S_IDLE;
          w_rep_cnt_nxt[i]   = '0;
        end else begin
          case (r_rep_state[i])
            S_IDLE: begin
              if (w_rise[i]) begin
                w_rep_state_nxt[i] = S_DELAY;
                w_rep_cnt_nxt[i]   = '0;
              end
            end
            S_DELAY: begin
              if (r_rep_cnt[i] + 8'd1 == DLY_CNT) begin
                w_rep_state_nxt[i] = S_REPEAT;
                w_rep_cnt_nxt[i]   = '0;
                w_rep_pulse[i]     = 1'b1;
              end else begin
                w_rep_cnt_nxt[i] = r_rep_cnt[i] + 8'd1;
              end
            end
            S_REPEAT: begin
              if (r_rep_cnt[i] + 8'd1 == RATE_CNT) begin
                w_rep_cnt_nxt[i] = '0;
                w_rep_pulse[i]   = 1'b1;
              end else begin
                w_rep_cnt_nxt[i] = r_rep_cnt[i] + 8'd1;
              end
            end
            default: begin
              w_rep_state_nxt[i] = S_IDLE;
              w_rep_cnt_nxt[i]   = '0;
            end
          endcase
        end
      end
    end
  end

  assign w_press_all = w_rise | {1'b0, w_rep_pulse};
`else
  logic w_unused_rep_cfg;
  assign w_unused_rep_cfg = ^{8'(REP_DELAY), 8'(REP_RATE)};
  assign w_press_all      = w_rise;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_vblank_q  <= 1'b0;
      r_tick      <= 1'b0;
      r_level     <= '0;
      r_press     <= '0;
      r_frame_cnt <= '0;
      for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_vblank_q <= bus.vblank;
      r_tick     <= w_edge;
      r_level    <= w_level_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_press    <= w_press_all;
      if (w_edge) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.frame_tick = r_tick;
  assign bus.btn_level  = r_level;
  assign bus.btn_press  = r_press;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_joy_frame_sched.sv
// Self-checking bench for joy_frame_sched: frame-level model compared every
// cycle, plus literal checks on the directed scenarios.
module tb_joy_frame_sched;
  localparam int DEB = 2;
  localparam int DLY = 20;
  localparam int RATE = 6;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  joy_frame_sched_if bus ();

  joy_frame_sched #(.DEB_FRAMES(DEB), .REP_DELAY(DLY), .REP_RATE(RATE)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: per-tick rules only, no cycle-level structure.
  logic        m_valid = 1'b0;
  logic        m_prev_vb;
  logic        m_tick;
  logic [4:0]  m_level, m_press;
  logic [15:0] m_cnt;
  int          m_dis  [5];
  int          m_hold [5];

  function automatic logic [4:0] socd(input logic [4:0] j);
    logic [4:0] s;
    s = j;
    if (j[3] && j[2]) s[3:2] = 2'b00;
    if (j[1] && j[0]) s[1:0] = 2'b00;
    return s;
  endfunction

  always @(posedge clk_sys) begin
    logic       e;
    logic [4:0] s, rose;
    if (reset) begin
      m_valid = 1'b1; m_prev_vb = 1'b0; m_tick = 1'b0;
      m_level = '0; m_press = '0; m_cnt = '0;
      for (int i = 0; i < 5; i++) begin m_dis[i] = 0; m_hold[i] = -1; end
    end else begin
      e = bus.vblank && !m_prev_vb;
      m_prev_vb = bus.vblank;
      m_tick  = e;
      m_press = '0;
      if (e) begin
        m_cnt = m_cnt + 16'd1;
        s = socd(bus.joy);
        rose = '0;
        for (int i = 0; i < 5; i++) begin
          if (s[i] != m_level[i]) begin
            m_dis[i]++;
            if (m_dis[i] == DEB) begin
              m_level[i] = ~m_level[i];
              m_dis[i] = 0;
              if (m_level[i]) begin rose[i] = 1'b1; m_hold[i] = 0; end
            end
          end else begin
            m_dis[i] = 0;
          end
        end
        m_press = rose;
        for (int i = 0; i < 5; i++) begin
          if (!m_level[i]) m_hold[i] = -1;
          else if (!rose[i] && m_hold[i] >= 0) begin
            m_hold[i]++;
`ifdef JOY_FRAME_SCHED_AUTOREPEAT_EN
            if (i < 4 && m_hold[i] >= DLY && ((m_hold[i] - DLY) % RATE) == 0)
              m_press[i] = 1'b1;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (m_valid) begin
      chk("model frame_tick", 32'(bus.frame_tick), 32'(m_tick));
      chk("model btn_level",  32'(bus.btn_level),  32'(m_level));
      chk("model btn_press",  32'(bus.btn_press),  32'(m_press));
      chk("model frame_cnt",  32'(bus.frame_cnt),  32'(m_cnt));
    end
  end

  int          tick_no;
  logic        t_tick;
  logic [4:0]  t_level, t_press;
  logic [15:0] t_cnt;

  task automatic do_frame(input logic [4:0] j);
    bus.joy = j;
    bus.vblank = 1'b1;
    @(negedge clk_sys);
    tick_no++;
    t_tick = bus.frame_tick; t_level = bus.btn_level;
    t_press = bus.btn_press; t_cnt = bus.frame_cnt;
    bus.vblank = 1'b0;
    bus.joy = ~j;
    repeat (5) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    bus.vblank = 1'b0;
    bus.joy = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    tick_no = 0;
  endtask

  initial begin
    logic [63:0] pmask, exp_mask;
    int ticks;
    bus.vblank = 1'b0;
    bus.joy = '0;
    @(negedge clk_sys);
    do_reset();
    chk("reset frame_tick", 32'(bus.frame_tick), 0);
    chk("reset btn_level",  32'(bus.btn_level), 0);
    chk("reset frame_cnt",  32'(bus.frame_cnt), 0);

    // R held: level and press at the second tick
    do_frame(5'b00001);
    chk("R tick1 level", 32'(t_level), 0);
    chk("R tick1 cnt",   32'(t_cnt), 1);
    do_frame(5'b00001);
    chk("R tick2 frame_tick", 32'(t_tick), 1);
    chk("R tick2 level", 32'(t_level), 32'h01);
    chk("R tick2 press", 32'(t_press), 32'h01);
    chk("R tick2 cnt",   32'(t_cnt), 2);

    // C glitch for one tick, then a fresh press
    do_frame(5'b10001);
    chk("C glitch level", 32'(t_level[4]), 0);
    chk("C glitch press", 32'(t_press), 0);
    do_frame(5'b00001);
    chk("C after glitch level", 32'(t_level[4]), 0);
    do_frame(5'b10001);
    chk("C restart count 1", 32'(t_level[4]), 0);
    do_frame(5'b10001);
    chk("C press level", 32'(t_level), 32'h11);
    chk("C press pulse", 32'(t_press), 32'h10);

    do_frame(5'b00000);
    do_frame(5'b00000);
    chk("release level", 32'(t_level), 0);
    chk("release press", 32'(t_press), 0);

    // U+D cancels
    for (int k = 0; k < 5; k++) begin
      do_frame(5'b01100);
      chk("UD level", 32'(t_level[3:2]), 0);
      chk("UD press", 32'(t_press), 0);
    end

    // vblank held high: one tick only
    ticks = 0;
    bus.vblank = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_sys);
      if (bus.frame_tick) ticks++;
    end
    bus.vblank = 1'b0;
    @(negedge clk_sys);
    chk("held vblank ticks", 32'(ticks), 1);

    // U held 40 ticks
    do_reset();
    pmask = '0;
    for (int k = 0; k < 40; k++) begin
      do_frame(5'b01000);
      if (t_press[3]) pmask[tick_no] = 1'b1;
    end
    exp_mask = '0;
    exp_mask[2] = 1'b1;
`ifdef JOY_FRAME_SCHED_AUTOREPEAT_EN
    exp_mask[22] = 1'b1; exp_mask[28] = 1'b1;
    exp_mask[34] = 1'b1; exp_mask[40] = 1'b1;
`endif
    chk("U repeat mask lo", pmask[31:0], exp_mask[31:0]);
    chk("U repeat mask hi", pmask[63:32], exp_mask[63:32]);

    // C held 40 ticks: never repeats
    do_reset();
    pmask = '0;
    for (int k = 0; k < 40; k++) begin
      do_frame(5'b10000);
      if (t_press[4]) pmask[tick_no] = 1'b1;
    end
    exp_mask = '0;
    exp_mask[2] = 1'b1;
    chk("C repeat mask lo", pmask[31:0], exp_mask[31:0]);
    chk("C repeat mask hi", pmask[63:32], exp_mask[63:32]);

    // vblank high coming out of reset is an edge
    bus.joy = '0;
    bus.vblank = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("post-reset edge tick", 32'(bus.frame_tick), 1);
    chk("post-reset edge cnt",  32'(bus.frame_cnt), 1);
    bus.vblank = 1'b0;
    repeat (3) @(negedge clk_sys);

    // reset mid-debounce discards the pending count
    do_frame(5'b00001);
    chk("mid-deb level", 32'(t_level), 0);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("mid-deb reset tick",  32'(bus.frame_tick), 0);
    chk("mid-deb reset level", 32'(bus.btn_level), 0);
    chk("mid-deb reset press", 32'(bus.btn_press), 0);
    chk("mid-deb reset cnt",   32'(bus.frame_cnt), 0);
    reset = 1'b0;
    @(negedge clk_sys);
    do_frame(5'b00000);
    chk("after reset press", 32'(t_press), 0);
    chk("after reset level", 32'(t_level), 0);
    chk("after reset cnt",   32'(t_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
